// File: rtl/udiv_pkg.sv
// udiv_pkg: shared FSM state type and sizing helpers for the iterative divider
package udiv_pkg;
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  function automatic int udiv_iter(input int num_w, input int frac_w);
    return num_w + frac_w;
  endfunction
  function automatic int udiv_cnt_w(input int iter);
    return $clog2(iter + 1);
  endfunction
endpackage

// File: rtl/udiv_restore_step.sv
// udiv_restore_step: one combinational radix-2 restoring division step
module udiv_restore_step
  import udiv_pkg::*;
#(
  parameter int DEN_W = 8
) (
  input  logic [DEN_W+1:0] rem,
  input  logic             msb,
  input  logic [DEN_W:0]   div,
  output logic [DEN_W+1:0] rem_next,
  output logic             q
);
  logic [DEN_W+2:0] shifted;
  assign shifted = {rem, msb};
  assign q = shifted >= (DEN_W+3)'(div);
  assign rem_next = (DEN_W+2)'(q ? shifted - (DEN_W+3)'(div) : shifted);
endmodule

// File: rtl/udivision_fixed_iter.sv
// udivision_fixed_iter: iterative unsigned fixed-point divider with reciprocal mode
module udivision_fixed_iter
  import udiv_pkg::*;
#(
  parameter int NUM_W  = 16,
  parameter int DEN_W  = 8,
  parameter int FRAC_W = 8,
  parameter int OUT_W  = 16,
  parameter int TAG_W  = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [NUM_W-1:0] in_num,
  input  logic [DEN_W-1:0] in_den,
  input  logic             in_recip,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_quo,
  output logic             out_sat,
  output logic             out_dbz,
  output logic [TAG_W-1:0] out_tag
);
  localparam int ITER  = udiv_iter(NUM_W, FRAC_W);
  localparam int CNT_W = udiv_cnt_w(ITER);
  state_t           state;
  logic [ITER-1:0]  dvd;
  logic [ITER-1:0]  full;
  logic [DEN_W+1:0] rem;
  logic [DEN_W+1:0] rem_next;
  logic [DEN_W:0]   div;
  logic [CNT_W-1:0] cnt;
  logic [TAG_W-1:0] tag;
  logic             dbz;
  logic             q;
  logic             sat;
  logic             accept;
  assign in_ready = state == IDLE || (state == DONE && out_ready);
  assign accept = in_valid && in_ready;
  assign full = {dvd[ITER-2:0], q};
  assign sat = |(full >> OUT_W);
  udiv_restore_step #(.DEN_W(DEN_W)) step (
    .rem(rem),
    .msb(dvd[ITER-1]),
    .div(div),
    .rem_next(rem_next),
    .q(q)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      dvd       <= '0;
      rem       <= '0;
      div       <= '0;
      cnt       <= '0;
      tag       <= '0;
      dbz       <= 1'b0;
      out_valid <= 1'b0;
      out_quo   <= '0;
      out_sat   <= 1'b0;
      out_dbz   <= 1'b0;
      out_tag   <= '0;
    end else if (accept) begin
      state     <= BUSY;
      dvd       <= in_recip ? ITER'(1) << FRAC_W : {in_num, {FRAC_W{1'b0}}};
      div       <= {1'b0, in_den} + (DEN_W+1)'(in_recip);
      rem       <= '0;
      cnt       <= '0;
      tag       <= in_tag;
      dbz       <= !in_recip && in_den == '0;
      out_valid <= 1'b0;
    end else if (state == BUSY) begin
      dvd <= full;
      rem <= rem_next;
      cnt <= cnt + CNT_W'(1);
      if (cnt == CNT_W'(ITER - 1)) begin
        state     <= DONE;
        out_valid <= 1'b1;
        out_dbz   <= dbz;
        out_sat   <= !dbz && sat;
        out_quo   <= dbz || sat ? '1 : full[OUT_W-1:0];
        out_tag   <= tag;
      end
    end else if (state == DONE && out_ready) begin
      state     <= IDLE;
      out_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_udivision_fixed_iter.sv
// tb_udivision_fixed_iter: table, corner-sequence and randomized checks of the divider
module tb_udivision_fixed_iter;
  typedef struct packed {logic [15:0] quo; logic sat; logic dbz;} res_t;
  typedef struct packed {res_t r; logic [3:0] tag;} exp_t;
  typedef struct {
    logic [15:0] num;
    logic [7:0]  den;
    logic        recip;
    logic [3:0]  tag;
    logic [15:0] quo;
    logic        sat;
    logic        dbz;
  } vec_t;
  typedef struct {logic [7:0] den; logic [7:0] quo; logic sat;} leg_t;
  logic clk = 0;
  logic rst = 1;
  logic in_valid = 0, in_ready, in_recip = 0, out_valid, out_ready = 1, out_sat, out_dbz;
  logic [15:0] in_num = 0, out_quo;
  logic [7:0] in_den = 0;
  logic [3:0] in_tag = 0, out_tag;
  logic l_in_valid = 0, l_in_ready, l_out_valid, l_out_sat, l_out_dbz;
  logic [7:0] l_in_num = 0, l_in_den = 0, l_out_quo;
  logic [3:0] l_in_tag = 0, l_out_tag;
  int checks = 0;
  int failures = 0;
  always #5 clk = ~clk;
  udivision_fixed_iter dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_num(in_num),
    .in_den(in_den), .in_recip(in_recip), .in_tag(in_tag), .out_valid(out_valid),
    .out_ready(out_ready), .out_quo(out_quo), .out_sat(out_sat), .out_dbz(out_dbz),
    .out_tag(out_tag)
  );
  udivision_fixed_iter #(.NUM_W(8), .DEN_W(8), .FRAC_W(8), .OUT_W(8), .TAG_W(4)) leg (
    .clk(clk), .rst(rst), .in_valid(l_in_valid), .in_ready(l_in_ready), .in_num(l_in_num),
    .in_den(l_in_den), .in_recip(1'b1), .in_tag(l_in_tag), .out_valid(l_out_valid),
    .out_ready(1'b1), .out_quo(l_out_quo), .out_sat(l_out_sat), .out_dbz(l_out_dbz),
    .out_tag(l_out_tag)
  );
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  function automatic res_t model(input longint num, input longint den, input bit recip,
                                 input int fw, input int ow);
    res_t r;
    longint mx, q, n, d;
    mx = (longint'(1) << ow) - 1;
    n = recip ? 1 : num;
    d = recip ? den + 1 : den;
    r.dbz = !recip && den == 0;
    q = 0;
    if (!r.dbz) q = (n << fw) / d;
    r.sat = !r.dbz && q > mx;
    r.quo = (r.dbz || r.sat) ? 16'(mx) : 16'(q);
    return r;
  endfunction
  task automatic run_dflt(input logic [15:0] num, input logic [7:0] den, input logic recip,
                          input logic [3:0] tag, output res_t r, output logic [3:0] tg,
                          output int lat);
    int w;
    @(negedge clk);
    in_valid = 1; in_num = num; in_den = den; in_recip = recip; in_tag = tag; out_ready = 1;
    w = 0;
    while (!in_ready && w < 100) begin @(negedge clk); w++; end
    @(negedge clk);
    in_valid = 0;
    lat = 1;
    while (!out_valid && lat < 100) begin @(negedge clk); lat++; end
    r = '{out_quo, out_sat, out_dbz};
    tg = out_tag;
  endtask
  task automatic run_leg(input logic [7:0] den, output res_t r, output int lat);
    @(negedge clk);
    l_in_valid = 1; l_in_den = den; l_in_num = 8'($urandom); l_in_tag = 4'(den);
    @(negedge clk);
    l_in_valid = 0;
    lat = 1;
    while (!l_out_valid && lat < 100) begin @(negedge clk); lat++; end
    r = '{{8'h00, l_out_quo}, l_out_sat, l_out_dbz};
  endtask
  vec_t vt[9];
  leg_t lt[7];
  initial begin
    res_t r;
    logic [3:0] tg;
    int lat, w, sent, got, cyc, seen, sel;
    exp_t q_exp[$];
    exp_t e;
    vt = '{
      '{16'd3,    8'd2,   1'b0, 4'h1, 16'h0180, 1'b0, 1'b0},
      '{16'hFFFF, 8'd1,   1'b0, 4'h2, 16'hFFFF, 1'b1, 1'b0},
      '{16'd5,    8'd0,   1'b0, 4'h3, 16'hFFFF, 1'b0, 1'b1},
      '{16'd10,   8'd5,   1'b0, 4'h4, 16'h0200, 1'b0, 1'b0},
      '{16'd77,   8'd0,   1'b1, 4'h5, 16'h0100, 1'b0, 1'b0},
      '{16'h00FF, 8'hFF,  1'b0, 4'h6, 16'h0100, 1'b0, 1'b0},
      '{16'd1000, 8'd3,   1'b0, 4'h7, 16'hFFFF, 1'b1, 1'b0},
      '{16'd0,    8'd7,   1'b0, 4'h8, 16'h0000, 1'b0, 1'b0},
      '{16'h00FF, 8'h80,  1'b0, 4'h9, 16'h01FE, 1'b0, 1'b0}
    };
    lt = '{
      '{8'd0, 8'hFF, 1'b1}, '{8'd1, 8'h80, 1'b0}, '{8'd2, 8'h55, 1'b0}, '{8'd4, 8'h33, 1'b0},
      '{8'd127, 8'h02, 1'b0}, '{8'd128, 8'h01, 1'b0}, '{8'd255, 8'h01, 1'b0}
    };
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_outputs", {out_quo, out_sat, out_dbz, out_tag}, 0);
    rst = 0;
    @(negedge clk);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_leg_ready", l_in_ready, 1);
    for (int i = 0; i < 9; i++) begin
      run_dflt(vt[i].num, vt[i].den, vt[i].recip, vt[i].tag, r, tg, lat);
      chk($sformatf("tbl%0d_quo", i), r.quo, vt[i].quo);
      chk($sformatf("tbl%0d_sat", i), r.sat, vt[i].sat);
      chk($sformatf("tbl%0d_dbz", i), r.dbz, vt[i].dbz);
      chk($sformatf("tbl%0d_tag", i), tg, vt[i].tag);
      chk($sformatf("tbl%0d_lat", i), lat, 25);
    end
    @(negedge clk);
    out_ready = 0; in_valid = 1; in_num = 16'h1234; in_den = 8'h40; in_recip = 0; in_tag = 4'h3;
    @(negedge clk);
    in_valid = 0;
    w = 0;
    while (!out_valid && w < 100) begin @(negedge clk); w++; end
    in_valid = 1; in_num = 16'd10; in_den = 8'd5; in_tag = 4'hA;
    for (int i = 0; i < 10; i++) begin
      #1;
      chk("bp_hold", {out_valid, in_ready, out_sat, out_dbz, out_tag, out_quo},
          {1'b1, 1'b0, 1'b0, 1'b0, 4'h3, 16'h48D0});
      @(negedge clk);
    end
    out_ready = 1;
    #1;
    chk("bp_ready_follows_out_ready", in_ready, 1);
    @(negedge clk);
    chk("bp_accepted_no_bubble", {out_valid, in_ready}, 2'b00);
    in_valid = 0;
    lat = 1;
    while (!out_valid && lat < 100) begin @(negedge clk); lat++; end
    chk("b2b_quo", {out_quo, out_sat, out_dbz}, {16'h0200, 2'b00});
    chk("b2b_tag", out_tag, 4'hA);
    chk("b2b_lat", lat, 25);
    @(negedge clk);
    in_valid = 1; in_num = 16'd100; in_den = 8'd3; in_tag = 4'h5;
    @(posedge clk);
    repeat (12) @(posedge clk);
    @(negedge clk);
    in_valid = 0; rst = 1;
    @(negedge clk);
    rst = 0;
    #1;
    chk("midrst_in_ready", in_ready, 1);
    chk("midrst_outputs", {out_valid, out_quo, out_tag}, 0);
    seen = 0;
    for (int i = 0; i < 40; i++) begin @(negedge clk); if (out_valid) seen = 1; end
    chk("midrst_no_result", seen, 0);
    run_dflt(16'd100, 8'd3, 1'b0, 4'h6, r, tg, lat);
    chk("midrst_next_quo", r, {16'h2155, 2'b00});
    chk("midrst_next_tag", tg, 4'h6);
    for (int i = 0; i < 7; i++) begin
      run_leg(lt[i].den, r, lat);
      chk($sformatf("leg_den%0d", lt[i].den), {r.sat, r.dbz, r.quo}, {lt[i].sat, 1'b0, 8'h00, lt[i].quo});
    end
    chk("leg_lat", lat, 17);
    for (int d = 0; d < 256; d++) begin
      run_leg(8'(d), r, lat);
      chk($sformatf("leg_sweep%0d", d), r, model(0, d, 1'b1, 8, 8));
    end
    sent = 0; got = 0; cyc = 0;
    while (got < 1500 && cyc < 60000) begin
      @(negedge clk);
      in_valid = sent < 1500 && $urandom_range(0, 3) != 0;
      sel = $urandom_range(0, 7);
      in_num = sel < 2 ? 16'($urandom_range(0, 255)) : 16'($urandom);
      sel = $urandom_range(0, 7);
      in_den = sel == 0 ? 8'd0 : sel == 1 ? 8'($urandom_range(1, 3)) : 8'($urandom);
      in_recip = $urandom_range(0, 3) == 0;
      in_tag = 4'($urandom);
      out_ready = $urandom_range(0, 3) != 0;
      #1;
      if (out_valid && out_ready) begin
        if (q_exp.size() == 0) chk("rnd_unexpected_result", 1, 0);
        else begin
          e = q_exp.pop_front();
          chk("rnd_result", {out_quo, out_sat, out_dbz, out_tag}, e);
        end
        got++;
      end
      if (in_valid && in_ready) begin
        q_exp.push_back('{model(in_num, in_den, in_recip, 8, 16), in_tag});
        sent++;
      end
      cyc++;
    end
    chk("rnd_all_retired", got, 1500);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
